// File: rtl/cv32e40p_fetch_addr_ctrl.sv
// rtl/cv32e40p_fetch_addr_ctrl.sv - IF-stage fetch address controller issuing OBI instruction requests
//
// Latches the redirect target on branch_i and issues sequential word-aligned
// fetches. Up to DEPTH transactions may be outstanding. Responses that belong
// to a stream abandoned by a branch are dropped. Accepted words are forwarded
// to the instruction buffer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   fetch_enable_i      allows new requests
//   branch_i            redirect strobe
//   branch_addr_i       redirect target (aligned down to a word)
//   ready_i             downstream can absorb one more response
//   trans_req_o         OBI request
//   trans_addr_o        OBI address (word aligned)
//   trans_gnt_i         OBI grant
//   trans_rvalid_i      OBI response valid
//   trans_rdata_i       OBI response data
//   fetch_valid_o       instruction word valid to buffer
//   fetch_rdata_o       instruction word
//   busy_o              transactions outstanding, flushes pending or request active
//   trans_err_i         OBI response error          (CV32E40P_FETCH_ERR_EN only)
//   fetch_err_o         forwarded word carries error (CV32E40P_FETCH_ERR_EN only)
//
// Build option: define CV32E40P_FETCH_ERR_EN to add error reporting; after a
// forwarded error no new requests start until the next branch.

module cv32e40p_fetch_addr_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_enable_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        trans_req_o,
    output logic [31:0] trans_addr_o,
    input  logic        trans_gnt_i,
    input  logic        trans_rvalid_i,
    input  logic [31:0] trans_rdata_i,
`ifdef CV32E40P_FETCH_ERR_EN
    input  logic        trans_err_i,
    output logic        fetch_err_o,
`endif
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        busy_o
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        BRANCH_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     tgt_q, tgt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   flush_q, flush_d;
    logic            pend_q, pend_d;
    logic            err_blk;

    logic [31:0]     branch_tgt;
    logic            issue;
    logic            rsp;
    logic            flush_rsp;

    assign branch_tgt = {branch_addr_i[31:2], 2'b00};
    assign issue      = trans_req_o & trans_gnt_i;
    // Responses with nothing outstanding (e.g. stragglers across a reset)
    // are not counted, so the counters cannot underflow.
    assign rsp        = trans_rvalid_i & (cnt_q != '0);
    assign flush_rsp  = rsp & (flush_q != '0);

`ifdef CV32E40P_FETCH_ERR_EN
    logic err_q, err_d;

    assign fetch_err_o = fetch_valid_o & trans_err_i;
    assign err_blk     = err_q;

    always_comb begin
        err_d = err_q;
        if (fetch_err_o) begin
            err_d = 1'b1;
        end
        if (branch_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign err_blk = 1'b0;
`endif

    // Request: a raised request is held (pend_q) until granted; new requests
    // only start with room for another outstanding transaction.
    always_comb begin
        trans_req_o = 1'b0;
        case (state_q)
            BUSY:        trans_req_o = pend_q | (fetch_enable_i & ready_i &
                                       (cnt_q < CW'(DEPTH)) & ~err_blk);
            BRANCH_WAIT: trans_req_o = 1'b1;
            default:     trans_req_o = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        pend_d  = trans_req_o & ~trans_gnt_i;
        cnt_d   = cnt_q + CW'(issue) - CW'(rsp);
        flush_d = flush_q - CW'(flush_rsp);

        case (state_q)
            IDLE: begin
                if (branch_i) begin
                    addr_d  = branch_tgt;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (issue) begin
                    addr_d = addr_q + 32'd4;
                end
                if (branch_i) begin
                    // Everything still outstanding after this cycle,
                    // including a transaction granted right now, is stale.
                    flush_d = cnt_d;
                    if (trans_req_o & ~trans_gnt_i) begin
                        tgt_d   = branch_tgt;
                        state_d = BRANCH_WAIT;
                    end else begin
                        addr_d = branch_tgt;
                    end
                end
            end
            BRANCH_WAIT: begin
                if (branch_i) begin
                    tgt_d = branch_tgt;
                end
                if (trans_gnt_i) begin
                    // The held request belongs to the old stream.
                    flush_d = flush_q - CW'(flush_rsp) + CW'(1'b1);
                    addr_d  = branch_i ? branch_tgt : tgt_q;
                    state_d = BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            flush_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            pend_q  <= pend_d;
        end
    end

    assign trans_addr_o  = addr_q;
    assign fetch_valid_o = trans_rvalid_i & (flush_q == '0) & ~branch_i;
    assign fetch_rdata_o = trans_rdata_i;
    assign busy_o        = (cnt_q != '0) | (flush_q != '0) | trans_req_o;

endmodule
